// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
//   Shared definitions for the 1:4 stream demultiplexer.
//   NLANES      : number of output lanes
//   lane_idx_t  : lane index type (2 bits)
//   sel_to_lane : packs the direct-mode select pins into a lane index
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int NLANES = 4;

    typedef logic [1:0] lane_idx_t;

    // sel1 is the MSB of the lane number, sel0 the LSB.
    function automatic lane_idx_t sel_to_lane(input logic sel1, input logic sel0);
        return lane_idx_t'({sel1, sel0});
    endfunction

endpackage

// File: rtl/demux_lane.sv
// ---------------------------------------------------------------------------
// demux_lane
//   One-entry holding register for a single output lane.
//   Ports:
//     clk   in   clock, rising edge
//     rst_n in   synchronous active-low reset
//     load  in   write data into the lane this edge
//     data  in   word to store
//     ready in   lane consumer takes the held word
//     valid out  lane holds a word (registered)
//     y     out  held word (registered)
// ---------------------------------------------------------------------------
module demux_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] y
);

    logic         valid_r;
    logic [W-1:0] y_r;

    // Holding register: a load wins over a drain so the lane sustains full rate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            y_r     <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            y_r     <= data;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
            y_r     <= y_r;
        end else begin
            valid_r <= valid_r;
            y_r     <= y_r;
        end
    end

    assign valid = valid_r;
    assign y     = y_r;

endmodule

// File: rtl/demux_1_4_stream.sv
// ---------------------------------------------------------------------------
// demux_1_4_stream
//   Routes one valid/ready input stream to one of four output lanes. The lane
//   is {sel1,sel0} in direct mode or a round-robin pointer in rr mode. Each
//   lane buffers one word, so a stalled lane only blocks words aimed at it.
//   Ports:
//     clk, rst_n            clock / synchronous active-low reset
//     rr_mode               0: direct select, 1: round-robin
//     sel0, sel1            direct-mode lane select
//     i, i_valid, i_ready   input stream handshake
//     yN, yN_valid, yN_ready  lane N output handshake (N = 0..3)
//     rr_ptr                current round-robin pointer
//     acc_cnt               accepted-word counter, wraps
// ---------------------------------------------------------------------------
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rr_mode,
    input  logic             sel0,
    input  logic             sel1,
    input  logic [W-1:0]     i,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [W-1:0]     y0,
    output logic [W-1:0]     y1,
    output logic [W-1:0]     y2,
    output logic [W-1:0]     y3,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             y2_valid,
    output logic             y3_valid,
    input  logic             y0_ready,
    input  logic             y1_ready,
    input  logic             y2_ready,
    input  logic             y3_ready,
    output logic [1:0]       rr_ptr,
    output logic [CNT_W-1:0] acc_cnt
);

    lane_idx_t         tgt_s;
    lane_idx_t         rr_ptr_r;
    logic [CNT_W-1:0]  acc_cnt_r;
    logic              i_ready_s;
    logic              accept_s;
    logic [NLANES-1:0] lane_valid_s;
    logic [NLANES-1:0] lane_ready_s;
    logic [NLANES-1:0] lane_load_s;
    logic [W-1:0]      lane_y_s [NLANES];

    assign lane_ready_s = {y3_ready, y2_ready, y1_ready, y0_ready};

    // Target decode and acceptance: only the targeted lane's state gates i_ready.
    always_comb begin
        tgt_s       = sel_to_lane(sel1, sel0);
        lane_load_s = '0;
        if (rr_mode) begin
            tgt_s = rr_ptr_r;
        end else begin
            tgt_s = sel_to_lane(sel1, sel0);
        end
        i_ready_s = ~lane_valid_s[tgt_s] | lane_ready_s[tgt_s];
        accept_s  = i_valid & i_ready_s;
        if (accept_s) begin
            lane_load_s[tgt_s] = 1'b1;
        end else begin
            lane_load_s = '0;
        end
    end

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        demux_lane #(.W(W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (lane_load_s[g]),
            .data  (i),
            .ready (lane_ready_s[g]),
            .valid (lane_valid_s[g]),
            .y     (lane_y_s[g])
        );
    end

    // Round-robin pointer advances only on accepts in rr mode; a blocked lane is never skipped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= 2'd0;
        end else if (rr_mode && accept_s) begin
            rr_ptr_r <= rr_ptr_r + 2'd1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Accepted-word counter, free-running wrap in either mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt_r <= '0;
        end else if (accept_s) begin
            acc_cnt_r <= acc_cnt_r + CNT_W'(1);
        end else begin
            acc_cnt_r <= acc_cnt_r;
        end
    end

    assign i_ready  = i_ready_s;
    assign y0       = lane_y_s[0];
    assign y1       = lane_y_s[1];
    assign y2       = lane_y_s[2];
    assign y3       = lane_y_s[3];
    assign y0_valid = lane_valid_s[0];
    assign y1_valid = lane_valid_s[1];
    assign y2_valid = lane_valid_s[2];
    assign y3_valid = lane_valid_s[3];
    assign rr_ptr   = rr_ptr_r;
    assign acc_cnt  = acc_cnt_r;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// ---------------------------------------------------------------------------
// tb_demux_1_4_stream
//   Directed bench for demux_1_4_stream. A second instance with a 4-bit
//   counter shares the same stimulus so the counter wrap is reachable in a
//   few cycles.
// ---------------------------------------------------------------------------
module tb_demux_1_4_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rr_mode;
    logic        sel0;
    logic        sel1;
    logic [7:0]  i;
    logic        i_valid;
    logic        i_ready;
    logic [7:0]  y0, y1, y2, y3;
    logic        y0_valid, y1_valid, y2_valid, y3_valid;
    logic        y0_ready, y1_ready, y2_ready, y3_ready;
    logic [1:0]  rr_ptr;
    logic [15:0] acc_cnt;

    logic        s_i_ready;
    logic [7:0]  s_y0, s_y1, s_y2, s_y3;
    logic        s_y0_valid, s_y1_valid, s_y2_valid, s_y3_valid;
    logic [1:0]  s_rr_ptr;
    logic [3:0]  s_acc_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    demux_1_4_stream #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .sel0(sel0), .sel1(sel1),
        .i(i), .i_valid(i_valid), .i_ready(i_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .y0_valid(y0_valid), .y1_valid(y1_valid), .y2_valid(y2_valid), .y3_valid(y3_valid),
        .y0_ready(y0_ready), .y1_ready(y1_ready), .y2_ready(y2_ready), .y3_ready(y3_ready),
        .rr_ptr(rr_ptr), .acc_cnt(acc_cnt)
    );

    demux_1_4_stream #(.W(8), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .sel0(sel0), .sel1(sel1),
        .i(i), .i_valid(i_valid), .i_ready(s_i_ready),
        .y0(s_y0), .y1(s_y1), .y2(s_y2), .y3(s_y3),
        .y0_valid(s_y0_valid), .y1_valid(s_y1_valid), .y2_valid(s_y2_valid), .y3_valid(s_y3_valid),
        .y0_ready(y0_ready), .y1_ready(y1_ready), .y2_ready(y2_ready), .y3_ready(y3_ready),
        .rr_ptr(s_rr_ptr), .acc_cnt(s_acc_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_valids(input string tag, input logic [3:0] exp);
        check_val(tag, {28'd0, y3_valid, y2_valid, y1_valid, y0_valid}, {28'd0, exp});
    endtask

    initial begin
        logic [7:0] rr_data [5];
        logic [1:0] rr_lane [5];
        logic [7:0] got_y;

        rst_n = 1'b0; rr_mode = 1'b0; sel0 = 1'b0; sel1 = 1'b0;
        i = 8'h00; i_valid = 1'b0;
        y0_ready = 1'b0; y1_ready = 1'b0; y2_ready = 1'b0; y3_ready = 1'b0;

        // 1: reset for two cycles
        step();
        step();
        check_valids("rst_valids", 4'b0000);
        check_val("rst_y", {y3, y2, y1, y0}, 32'h0000_0000);
        check_val("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
        check_val("rst_acc_cnt", {16'd0, acc_cnt}, 32'd0);
        check_val("rst_i_ready", {31'd0, i_ready}, 32'd1);

        // 2: direct write to lane 2, then blocked repeat
        rst_n = 1'b1;
        sel1 = 1'b1; sel0 = 1'b0; i = 8'hA5; i_valid = 1'b1;
        #1;
        check_val("d_i_ready_empty", {31'd0, i_ready}, 32'd1);
        step();
        check_val("d_y2", {24'd0, y2}, 32'hA5);
        check_valids("d_valids", 4'b0100);
        check_val("d_acc1", {16'd0, acc_cnt}, 32'd1);
        check_val("d_i_ready_full", {31'd0, i_ready}, 32'd0);
        i = 8'hFF;
        step();
        check_val("d_y2_hold", {24'd0, y2}, 32'hA5);
        check_val("d_acc_hold", {16'd0, acc_cnt}, 32'd1);

        // 3: lane 1 accepts while lane 2 is stalled
        sel1 = 1'b0; sel0 = 1'b1; i = 8'h3C;
        #1;
        check_val("iso_i_ready", {31'd0, i_ready}, 32'd1);
        step();
        check_val("iso_y1", {24'd0, y1}, 32'h3C);
        check_val("iso_y2", {24'd0, y2}, 32'hA5);
        check_valids("iso_valids", 4'b0110);
        check_val("iso_acc", {16'd0, acc_cnt}, 32'd2);

        // 4: full-rate pass-through on lane 0
        y0_ready = 1'b1; sel1 = 1'b0; sel0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            i = 8'(k);
            #1;
            check_val($sformatf("pt_i_ready_%0d", k), {31'd0, i_ready}, 32'd1);
            step();
            check_val($sformatf("pt_y0_%0d", k), {24'd0, y0}, k);
            check_val($sformatf("pt_y0_valid_%0d", k), {31'd0, y0_valid}, 32'd1);
        end
        check_val("pt_acc", {16'd0, acc_cnt}, 32'd5);
        i_valid = 1'b0;
        step();
        check_val("pt_drain_y0", {31'd0, y0_valid}, 32'd0);

        // 5: round-robin with all lanes draining; sel pins must be ignored
        y1_ready = 1'b1; y2_ready = 1'b1; y3_ready = 1'b1;
        step();
        check_valids("rr_pre_empty", 4'b0000);
        check_val("rr_pre_ptr", {30'd0, rr_ptr}, 32'd0);
        rr_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        rr_lane = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_mode = 1'b1; sel1 = 1'b1; sel0 = 1'b1; i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i = rr_data[k];
            step();
            case (rr_lane[k])
                2'd0:    got_y = y0;
                2'd1:    got_y = y1;
                2'd2:    got_y = y2;
                default: got_y = y3;
            endcase
            check_val($sformatf("rr_data_%0d", k), {24'd0, got_y}, {24'd0, rr_data[k]});
            check_valids($sformatf("rr_valids_%0d", k), 4'b0001 << rr_lane[k]);
        end
        check_val("rr_ptr_after", {30'd0, rr_ptr}, 32'd1);
        check_val("rr_acc", {16'd0, acc_cnt}, 32'd10);

        // 6: bring pointer to 2, fill lane 2 in direct mode, then block in rr mode
        i = 8'h15;
        step();
        check_val("rr_ptr_2", {30'd0, rr_ptr}, 32'd2);
        y2_ready = 1'b0;
        rr_mode = 1'b0; sel1 = 1'b1; sel0 = 1'b0; i = 8'h16;
        step();
        check_val("blk_y2", {24'd0, y2}, 32'h16);
        check_val("blk_ptr_direct_hold", {30'd0, rr_ptr}, 32'd2);
        check_val("blk_acc", {16'd0, acc_cnt}, 32'd12);
        rr_mode = 1'b1; sel1 = 1'b0; sel0 = 1'b0; i = 8'h17;
        #1;
        check_val("blk_i_ready", {31'd0, i_ready}, 32'd0);
        step();
        check_val("blk_ptr_stay", {30'd0, rr_ptr}, 32'd2);
        check_val("blk_y2_stay", {24'd0, y2}, 32'h16);
        check_val("blk_acc_stay", {16'd0, acc_cnt}, 32'd12);
        check_valids("blk_valids", 4'b0100);

        // reset mid-operation with an input still offered
        rst_n = 1'b0;
        step();
        check_valids("mrst_valids", 4'b0000);
        check_val("mrst_ptr", {30'd0, rr_ptr}, 32'd0);
        check_val("mrst_acc", {16'd0, acc_cnt}, 32'd0);
        check_val("mrst_y", {y3, y2, y1, y0}, 32'h0000_0000);

        // counter wrap on the 4-bit instance: 15 -> 0 on the 16th accept
        rst_n = 1'b1; rr_mode = 1'b0; sel1 = 1'b0; sel0 = 1'b0;
        y0_ready = 1'b1; i_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            i = 8'(8'h40 + k);
            step();
        end
        check_val("wrap_small_15", {28'd0, s_acc_cnt}, 32'd15);
        check_val("wrap_big_15", {16'd0, acc_cnt}, 32'd15);
        i = 8'h4F;
        step();
        check_val("wrap_small_0", {28'd0, s_acc_cnt}, 32'd0);
        check_val("wrap_big_16", {16'd0, acc_cnt}, 32'd16);
        check_val("wrap_y0", {24'd0, y0}, 32'h4F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
